block_memory: RTL
=================

Name: block_memory

Overview:
- Main-memory responder on the far side of the single-line data cache's block interface.
- Accepts a 512-bit dirty-block writeback (victim address plus data) and/or a 512-bit refill read (miss address); returns the refill block after a fixed access latency.
- Sits between the cache's miss-handling control and the backing store; the cache-side controller drives the requests and consumes `done`/`rdata_block`.
- A combined writeback + refill ("swap") request is serialised internally: write first, then read.

Parameters:
- `DEPTH_LOG2`, 8, log2 of the number of 64-byte blocks stored (256 blocks = 16 KiB).
- `LATENCY`, 4, cycles per array access; legal range 1..15.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `wb_req` input 1: writeback request, sampled only in IDLE.
- `wb_addr` input 32: writeback byte address; bits [5:0] are ignored.
- `wb_data` input 512: writeback block, word 0 in [31:0] and word 15 in [511:480].
- `rf_req` input 1: refill request, sampled only in IDLE.
- `rf_addr` input 32: refill byte address; bits [5:0] are ignored.
- `rdata_block` output 512: refill data; valid while `done`=1 and held until the next refill completes.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: high whenever state is not IDLE.

Behaviour:
- Index = addr[6+DEPTH_LOG2-1:6]. Upper address bits are ignored, so addresses alias modulo 2^(6+DEPTH_LOG2).
- States: IDLE, WB, RF, ACK.
- IDLE:
  - If `wb_req`: latch `wb_addr`, `wb_data`, `rf_addr` and rf_pending=`rf_req`; load cnt=LATENCY-1; go to WB.
  - Else if `rf_req`: latch `rf_addr`; load cnt=LATENCY-1; go to RF.
  - Else stay in IDLE.
- WB:
  - If cnt≠0: decrement cnt.
  - If cnt=0: write the latched block to mem[wb index]. Then, if rf_pending: reload cnt=LATENCY-1 and go to RF; otherwise go to ACK.
- RF:
  - If cnt≠0: decrement cnt.
  - If cnt=0: `rdata_block` <= mem[rf index]; go to ACK.
- ACK: `done`=1 for exactly this cycle; go to IDLE.
- Latency from the request-sampling edge to `done` high:
  - Single op: LATENCY+1 cycles.
  - Swap: 2*LATENCY+1 cycles.
- Requests and input data are ignored while `busy`=1 (including the ACK cycle). Inputs are captured only at the IDLE sampling edge, so changes to them after that edge have no effect.
- Back-to-back: the earliest next request is sampled in the IDLE cycle following ACK.
- Swap to the same index: the refill returns the just-written `wb_data`, because the write commits before the read.
- Writeback-only completion leaves `rdata_block` unchanged.
- Reset (asserted at any time, asynchronous):
  - state=IDLE, cnt=0, rf_pending=0, `done`=0, `busy`=0, `rdata_block`=0.
  - An in-flight write that has not reached cnt=0 is not committed; no `done` is produced.
- Array contents are not reset. The bench preloads them via hierarchical access or performs writes first.
- `cnt` width is 4 bits. LATENCY=1 means each access completes in its first cycle in WB/RF.

Decomposition:
- Shared package `mem_pkg`:
  - BLOCK_BITS=512, WORD_BITS=32, OFFSET_BITS=6.
  - State encoding: IDLE=2'd0, WB=2'd1, RF=2'd2, ACK=2'd3.
- One sub-module, `block_ram`: single-port, 2^DEPTH_LOG2 x 512, synchronous write, combinational read by index. The FSM, counter and latches stay in `block_memory`.

Test Plan:
- Reset, then idle with no requests → `busy`=0, `done`=0 and `rdata_block`=0 for 20 cycles.
- Preload mem[5] = {16{32'hA5A5_0005}}; `rf_req`=1, `rf_addr`=32'h0000_0140 for one cycle (LATENCY=4) → `busy`=1 on the next edge; `done`=1 exactly 5 cycles after the sampling edge with `rdata_block`={16{32'hA5A5_0005}}.
- `wb_req`=1, `wb_addr`=32'h0000_0080, `wb_data`={16{32'hDEAD_BEEF}}, then refill 32'h0000_0080 → first `done` at +5 with `rdata_block` unchanged; second `done` returns {16{32'hDEAD_BEEF}}.
- Swap: `wb_req`=`rf_req`=1, `wb_addr`=32'h0000_0100 with data {16{32'h1111_1111}}, `rf_addr`=32'h0000_0100 → a single `done` at +9 with `rdata_block`={16{32'h1111_1111}}. Repeat with `rf_addr`=32'h0004_0100 (aliases to index 4) → same data.
- Assert `rf_req`/`wb_req` while `busy`=1 and during ACK → ignored: exactly one `done` per accepted request, and the array is unmodified by the ignored writes.
- Start a writeback of {16{32'hCAFE_0000}} to index 7 (old contents 0), pull `rst` low 2 cycles after sampling (asynchronous, mid-clock) → outputs are 0 immediately; after release, a refill of index 7 returns 0 and no stray `done` appears.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the cache-side block memory.
package mem_pkg;

   localparam int unsigned BLOCK_BITS  = 512;
   localparam int unsigned WORD_BITS   = 32;
   localparam int unsigned OFFSET_BITS = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RF   = 2'd2,
      ACK  = 2'd3
   } state_t;

endpackage

// File: rtl/block_ram.sv
// Single-port block array: synchronous write, combinational read at the same index.
module block_ram
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [BLOCK_BITS-1:0] wdata,
   output logic [BLOCK_BITS-1:0] rdata
);

   logic [BLOCK_BITS-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/block_memory.sv
// Main-memory responder for cache writebacks and refills with a fixed per-access latency.
module block_memory
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_req,
   input  logic [31:0]           wb_addr,
   input  logic [BLOCK_BITS-1:0] wb_data,
   input  logic                  rf_req,
   input  logic [31:0]           rf_addr,
   output logic [BLOCK_BITS-1:0] rdata_block,
   output logic                  done,
   output logic                  busy
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t                state, state_n;
   logic [3:0]            cnt, cnt_n;
   logic                  rf_pending;
   logic [DEPTH_LOG2-1:0] wb_idx, rf_idx, ram_addr;
   logic [BLOCK_BITS-1:0] wb_data_q, ram_rdata;
   logic                  capture_wb, capture_rf, ram_we, rd_load;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{wb_addr[31:OFFSET_BITS+DEPTH_LOG2], wb_addr[OFFSET_BITS-1:0],
                               rf_addr[31:OFFSET_BITS+DEPTH_LOG2], rf_addr[OFFSET_BITS-1:0]};

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      capture_wb = 1'b0;
      capture_rf = 1'b0;
      ram_we     = 1'b0;
      rd_load    = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (wb_req) begin
               capture_wb = 1'b1;
               cnt_n      = CNT_INIT;
               state_n    = WB;
            end else if (rf_req) begin
               capture_rf = 1'b1;
               cnt_n      = CNT_INIT;
               state_n    = RF;
            end
         end
         WB: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               // write commits before a pending refill so a same-index swap reads new data
               ram_we = 1'b1;
               if (rf_pending) begin
                  cnt_n   = CNT_INIT;
                  state_n = RF;
               end else begin
                  state_n = ACK;
               end
            end
         end
         RF: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               rd_load = 1'b1;
               state_n = ACK;
            end
         end
         ACK: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign ram_addr = (state == WB) ? wb_idx : rf_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rf_pending  <= 1'b0;
         rdata_block <= '0;
         wb_idx      <= '0;
         rf_idx      <= '0;
         wb_data_q   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (capture_wb) begin
            wb_idx     <= wb_addr[OFFSET_BITS+DEPTH_LOG2-1:OFFSET_BITS];
            wb_data_q  <= wb_data;
            rf_idx     <= rf_addr[OFFSET_BITS+DEPTH_LOG2-1:OFFSET_BITS];
            rf_pending <= rf_req;
         end else if (capture_rf) begin
            rf_idx     <= rf_addr[OFFSET_BITS+DEPTH_LOG2-1:OFFSET_BITS];
            rf_pending <= 1'b0;
         end
         if (rd_load) rdata_block <= ram_rdata;
      end
   end

   block_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wb_data_q),
      .rdata (ram_rdata)
   );

endmodule
